// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the EX-stage shifter: op encodings and default widths.
// Optional feature macro: SHIFT_ROTR_EN (op 11 becomes rotate-right).
// -----------------------------------------------------------------------------
package shift_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int SHAMT_W_DEF = 5;
  localparam int TAG_W_DEF   = 5;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_ROTR = 2'b11
  } shift_op_e;

endpackage

// File: rtl/shift_stage.sv
// -----------------------------------------------------------------------------
// shift_stage
// Combinational partial-shift slice. Shifts i_data by (i_amt * GRAN) bits
// according to i_op. Two slices in series (GRAN=8, then GRAN=1) build the
// full barrel shifter.
// Optional feature macro: SHIFT_ROTR_EN (op 11 rotates right; otherwise op 11
// passes data through unchanged and no rotate logic exists).
//
// Ports:
//   i_op    op code (shift_pkg::shift_op_e encoding)
//   i_data  value to shift
//   i_amt   shift amount in units of GRAN bits
//   o_data  shifted value
// -----------------------------------------------------------------------------
module shift_stage
  import shift_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int AMT_W  = 2,
  parameter int GRAN   = 8
) (
  input  logic [1:0]        i_op,
  input  logic [DATA_W-1:0] i_data,
  input  logic [AMT_W-1:0]  i_amt,
  output logic [DATA_W-1:0] o_data
);

  int                       w_sh;
  logic signed [DATA_W-1:0] w_sdata;

  always_comb begin
    w_sh    = int'(i_amt) * GRAN;
    w_sdata = i_data;
    o_data  = i_data;
    case (shift_op_e'(i_op))
      OP_SLL:  o_data = i_data << w_sh;
      OP_SRL:  o_data = i_data >> w_sh;
      // Arithmetic shift on the signed view replicates the sign bit; in the
      // second slice the sign bit is already correct from the first slice.
      OP_SRA:  o_data = w_sdata >>> w_sh;
`ifdef SHIFT_ROTR_EN
      // With w_sh == 0 the left term shifts by DATA_W and yields zero.
      OP_ROTR: o_data = (i_data >> w_sh) | (i_data << (DATA_W - w_sh));
`endif
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/shift_exec_unit.sv
// -----------------------------------------------------------------------------
// shift_exec_unit
// EX-stage 2-stage pipelined barrel shifter for SLL/SRL/SRA and the variable
// forms. Stage 1 shifts by shamt[4:3]*8, stage 2 by shamt[2:0]. The destination
// tag travels with the data. valid/ready handshake on both sides.
// Optional feature macro: SHIFT_ROTR_EN (op 11 = ROTR; otherwise pass-through).
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   flush              synchronous kill of all in-flight ops; drops same-cycle input
//   in_valid/in_ready  input handshake
//   in_op              00 SLL, 01 SRL, 10 SRA, 11 ROTR/pass-through
//   in_data            value to shift
//   in_shamt           shift amount; only [SHAMT_W-1:0] used
//   in_tag             destination register number
//   out_valid/out_ready output handshake
//   out_data, out_tag  result and its tag, driven straight from stage-2 registers
// -----------------------------------------------------------------------------
module shift_exec_unit
  import shift_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF,
  parameter int TAG_W   = TAG_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_shamt,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int FINE_W   = 3;
  localparam int COARSE_W = SHAMT_W - FINE_W;

  logic [1:0]        r_op_p1;
  logic [TAG_W-1:0]  r_tag_p1;
  logic [FINE_W-1:0] r_fine_p1;
  logic [DATA_W-1:0] r_data_p1;
  logic              r_vld_p1;

  logic [DATA_W-1:0] r_data_p2;
  logic [TAG_W-1:0]  r_tag_p2;
  logic              r_vld_p2;

  logic [DATA_W-1:0] w_res_p1;
  logic [DATA_W-1:0] w_res_p2;
  logic              w_s1_adv;
  logic              w_s2_adv;
  logic              w_accept;
  logic              w_unused_shamt;

  // Upper shamt bits carry the rest of rs for the V-forms and are ignored.
  assign w_unused_shamt = ^in_shamt[DATA_W-1:SHAMT_W];

  assign w_s2_adv = !r_vld_p2 || out_ready;
  assign w_s1_adv = !r_vld_p1 || w_s2_adv;
  assign in_ready = w_s1_adv;
  assign w_accept = in_valid && w_s1_adv;

  // ---- Stage 1: coarse shift by shamt[4:3] * 8 ----
  shift_stage #(
    .DATA_W (DATA_W),
    .AMT_W  (COARSE_W),
    .GRAN   (8)
  ) u_stage_p1 (
    .i_op   (in_op),
    .i_data (in_data),
    .i_amt  (in_shamt[SHAMT_W-1:FINE_W]),
    .o_data (w_res_p1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1  <= 1'b0;
      r_op_p1   <= '0;
      r_tag_p1  <= '0;
      r_fine_p1 <= '0;
      r_data_p1 <= '0;
    end else if (flush) begin
      r_vld_p1  <= 1'b0;
    end else if (w_s1_adv) begin
      r_vld_p1 <= in_valid;
      if (w_accept) begin
        r_op_p1   <= in_op;
        r_tag_p1  <= in_tag;
        r_fine_p1 <= in_shamt[FINE_W-1:0];
        r_data_p1 <= w_res_p1;
      end
    end
  end

  // ---- Stage 2: fine shift by shamt[2:0] ----
  shift_stage #(
    .DATA_W (DATA_W),
    .AMT_W  (FINE_W),
    .GRAN   (1)
  ) u_stage_p2 (
    .i_op   (r_op_p1),
    .i_data (r_data_p1),
    .i_amt  (r_fine_p1),
    .o_data (w_res_p2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p2  <= 1'b0;
      r_tag_p2  <= '0;
      r_data_p2 <= '0;
    end else if (flush) begin
      r_vld_p2  <= 1'b0;
    end else if (w_s2_adv) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_tag_p2  <= r_tag_p1;
        r_data_p2 <= w_res_p2;
      end
    end
  end

  // ---- Output: registered stage-2 state ----
  assign out_valid = r_vld_p2;
  assign out_data  = r_data_p2;
  assign out_tag   = r_tag_p2;

endmodule
